// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with programmable prescaler.
//
// Counts a start value down to zero, one step per tick, where a tick occurs every
// prescale+1 enabled cycles. On reaching zero it emits a one-cycle tc_pulse and then
// either reloads (periodic) or stops in DONE and raises the sticky done flag (one-shot).
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-high reset
//   enable   - count enable; prescaler and count freeze while low
//   load     - start/reload value, sampled at start and at each periodic reload
//   start    - single-cycle request to (re)load and run; ignored when load == 0
//   stop     - single-cycle request to abort a run; no effect outside RUN
//   periodic - 1 = auto-reload on terminal count, 0 = one-shot
//   prescale - tick every prescale+1 enabled cycles (compared live)
//   count    - current count value
//   busy     - high while running
//   tc_pulse - one-cycle pulse on terminal count
//   done     - sticky one-shot completion flag, cleared by start or reset
module down_timer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      load,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  periodic,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc_pulse,
  output logic                  done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                state_q;
  logic [PRESCALE_W-1:0] presc_q;

  logic load_nz;
  assign load_nz = (load != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      count    <= '0;
      busy     <= 1'b0;
      tc_pulse <= 1'b0;
      done     <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (stop && state_q == StRun) begin
        // Abort: count holds, done untouched.
        state_q <= StIdle;
        busy    <= 1'b0;
        presc_q <= '0;
      end else if (start && load_nz) begin
        state_q <= StRun;
        busy    <= 1'b1;
        count   <= load;
        presc_q <= '0;
        done    <= 1'b0;
      end else if (state_q == StRun && enable) begin
        if (presc_q == prescale) begin
          presc_q <= '0;
          if (count > WIDTH'(1)) begin
            count <= count - WIDTH'(1);
          end else begin
            // Terminal count; RUN always holds count >= 1 so this is count == 1.
            tc_pulse <= 1'b1;
            if (periodic && load_nz) begin
              count <= load;
            end else begin
              count   <= '0;
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end else begin
          // Wraps through 2^PRESCALE_W if prescale was lowered below the counter.
          presc_q <= presc_q + PRESCALE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer.
module tb_down_timer;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned PRESCALE_W = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [WIDTH-1:0]      load;
  logic                  start;
  logic                  stop;
  logic                  periodic;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  tc_pulse;
  logic                  done;

  int n_checks = 0;
  int n_fails  = 0;

  down_timer #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .tc_pulse (tc_pulse),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all four outputs at once.
  task automatic chk_all(input string tag, input int c, input bit b, input bit t, input bit d);
    chk({tag, ".count"},    32'(count),    32'(c));
    chk({tag, ".busy"},     32'(busy),     32'(b));
    chk({tag, ".tc_pulse"}, 32'(tc_pulse), 32'(t));
    chk({tag, ".done"},     32'(done),     32'(d));
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    load     = '0;
    start    = 1'b0;
    stop     = 1'b0;
    periodic = 1'b0;
    prescale = '0;
    step();
    step();
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();

    // One-shot, load=5, prescale=0
    load = 8'd5; prescale = 4'd0; periodic = 1'b0; enable = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("os_start", 5, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_all($sformatf("os_cnt%0d", i), 5 - i, 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_all("os_tc", 0, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("os_after", 0, 1'b0, 1'b0, 1'b1);

    // Periodic, load=3, prescale=2: tick every 3 cycles, pulse every 9
    load = 8'd3; prescale = 4'd2; periodic = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("per_start", 3, 1'b1, 1'b0, 1'b0);
    for (int j = 1; j <= 20; j++) begin
      step();
      chk_all($sformatf("per_j%0d", j), 3 - ((j / 3) % 3), 1'b1, (j % 9) == 0, 1'b0);
    end
    // Edge 21 would be a tick; stop wins and count holds at 3.
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("per_stop", 3, 1'b0, 1'b0, 1'b0);

    // Enable gap: load=4, hold enable low 3 cycles at count=2
    load = 8'd4; prescale = 4'd0; periodic = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("en_start", 4, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("en_c3", 3, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("en_c2", 2, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("en_hold%0d", i), 2, 1'b1, 1'b0, 1'b0);
    end
    enable = 1'b1;
    step();
    chk_all("en_c1", 1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("en_tc", 0, 1'b0, 1'b1, 1'b1);

    // Stop beats start in the same cycle
    load = 8'd10; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("ss_start", 10, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("ss_cnt", 32'(count), 32'(10 - i));
    end
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk_all("ss_stopwin", 6, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("ss_idle", 6, 1'b0, 1'b0, 1'b0);
    load = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("ss_l2", 2, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("ss_l2c1", 1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("ss_l2tc", 0, 1'b0, 1'b1, 1'b1);

    // load=0 start from IDLE is ignored; then restart mid-run
    reset = 1'b1;
    step();
    reset = 1'b0;
    load = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("z_ignored", 0, 1'b0, 1'b0, 1'b0);
    load = 8'd8; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("rs_start", 8, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("rs_cnt", 32'(count), 32'(8 - i));
    end
    load = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("rs_restart", 2, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("rs_c1", 1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("rs_tc", 0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-run in periodic mode
    load = 8'd9; periodic = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk_all("ar_pre", 7, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("ar_async", 0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_all($sformatf("ar_quiet%0d", i), 0, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting timer with programmable prescaler, one-shot and periodic (auto-reload) modes.
- Counts a start value down to zero and emits a one-cycle terminal-count pulse. Flags completion in one-shot mode.
- Complements the design's up counter. Used to generate timeouts and periodic ticks from the system clock.

Parameters:
- WIDTH, 8, width of count, load and reload value.
- PRESCALE_W, 4, width of prescaler compare value and internal prescale counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count enable. When low, prescaler and count are frozen.
- load  input  WIDTH  start/reload value. Sampled at start and at each periodic reload.
- start  input  1  single-cycle request to (re)load the count and run.
- stop  input  1  single-cycle request to abort the run.
- periodic  input  1  1 = auto-reload on terminal count, 0 = one-shot. Sampled at each tick.
- prescale  input  PRESCALE_W  a tick occurs every prescale+1 enabled cycles.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high while in RUN.
- tc_pulse  output  1  one-cycle pulse when count reaches 0.
- done  output  1  sticky flag, one-shot completion. Cleared by start or reset.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - count=0, busy=0, tc_pulse=0, done=0.
  - prescale counter=0.
- All outputs are registered. tc_pulse defaults to 0 every cycle unless set by a tick.
- States: IDLE, RUN, DONE. busy = (state==RUN).
- Priority within a cycle: reset > stop > start > tick.
- IDLE/DONE + start, load!=0:
  - count<=load, prescale counter<=0, done<=0, state<=RUN.
  - busy is high after that edge.
- IDLE/DONE + start, load==0: request ignored. No state or output change.
- RUN + start, load!=0: restart. count<=load, prescale counter<=0, no tc_pulse. Same rule as the IDLE/DONE case.
- RUN + start, load==0: ignored (stays RUN).
- RUN + stop:
  - state<=IDLE, prescale counter<=0, count holds its value.
  - no tc_pulse, done unchanged.
  - stop in IDLE or DONE has no effect.
- Tick: in RUN with enable=1 and prescale counter==prescale.
  - On tick, prescale counter<=0.
  - Otherwise, if enable=1 and in RUN, prescale counter increments.
  - prescale=0 gives a tick every enabled cycle.
- On tick with count>1: count<=count-1.
- On tick with count==1: tc_pulse<=1 for exactly one cycle, then:
  - periodic=1 and load!=0: count<=load, stay RUN.
  - periodic=1 and load==0: count<=0, state<=DONE, done<=1.
  - periodic=0: count<=0, state<=DONE, done<=1.
- Latency: start at edge N, load=L, prescale=P, enable held high.
  - tc_pulse is high in the cycle after edge N + L*(P+1).
  - In periodic mode with constant L, the pulse repeats every L*(P+1) cycles.
- enable low mid-run: count and prescale counter hold. Timing resumes exactly where it stopped. start and stop still act.
- Prescale is compared live. If prescale is lowered below the current prescale counter value, the counter wraps through 2^PRESCALE_W before ticking. No error flag.
- Reset mid-run: immediate return to reset values. No tc_pulse is generated.
- Count never underflows. The 0 state is only reached via the terminal-count path.

Test Plan:
- Reset, then load=5, prescale=0, periodic=0, enable=1, pulse start at edge N:
  - count reads 5,4,3,2,1,0 on edges N..N+5.
  - tc_pulse high for one cycle after edge N+5, done=1, busy=0.
- load=3, prescale=2, periodic=1, start, run 20 cycles:
  - tc_pulse every 9 cycles. Count sequence 3,2,1,3…
  - busy stays 1, done stays 0.
- load=4, prescale=0, start, drop enable for 3 cycles after count=2, then raise it:
  - tc_pulse arrives 3 cycles later than nominal.
  - count holds 2 while enable is low.
- load=10, start, stop when count=6 with start asserted in the same cycle:
  - IDLE, count=6, busy=0, no tc_pulse (stop wins).
  - A later start with load=2 gives tc_pulse 2 cycles after the start edge.
- start with load=0 from IDLE: no change (busy=0, count=0).
  - Then load=8 start, and restart with load=2 at count=5: tc_pulse 2 cycles after the restart.
- Assert reset asynchronously mid-run at count=7, periodic=1:
  - count=0, busy=0, done=0, tc_pulse=0 immediately, without waiting for a clock edge.
  - No pulse after reset release until a new start.
